shift_operand_sequencer: RTL
============================

Name: shift_operand_sequencer

Overview:
- Multi-cycle controller for register-specified data-processing shifts (shift amount taken from Rs[7:0]).
- Sequences a narrow STEP-bit shifter over several cycles and applies the ARM boundary rules for amounts 0, 32 and above 32.
- Produces the shifter operand and shifter carry-out for the ALU.
- Sits beside the immediate shift/sign-extend unit; the control unit stalls on busy until done.

Parameters:
STEP, 4, bits shifted per cycle; legal values 1, 2, 4, 8.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; accepted only when busy=0
shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR (IR[6:5])
amount  input  8  shift amount, Rs[7:0]
operand  input  32  value to shift (Rm)
carry_in  input  1  current CPSR C flag
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse when result is valid
result  output  32  shifter operand
carry_out  output  1  shifter carry-out

Behaviour:
- Reset (asynchronous): state=IDLE; busy=0, done=0, result=0, carry_out=0.
- Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- Accept: in IDLE with start=1 at edge 0, latch operand, shift_type, amount and carry_in. Later input changes are ignored.
- start is ignored in RUN and DONE.
- Effective step count E, computed at accept:
  - LSL, LSR: min(amount, 33)
  - ASR: min(amount, 32)
  - ROR: amount[4:0]
- Special cases (go directly to DONE, E treated as 0):
  - amount==0, any type: result=operand, carry_out=carry_in.
  - ROR with amount!=0 and amount[4:0]==0: result=operand, carry_out=operand[31].
- RUN step: each cycle shifts by s=min(STEP, remaining).
  - Fill: LSL/LSR fill with 0; ASR fills with the latched operand[31]; ROR rotates.
  - Carry register takes the last bit shifted out (ROR: the new bit 31).
  - remaining -= s.
  - RUN lasts ceil(E/STEP) cycles, then DONE.
- Resulting values, which stepping must reproduce exactly:
  - LSL 32: result 0, C=op[0].
  - LSR 32: result 0, C=op[31].
  - LSL/LSR above 32: result 0, C=0.
  - ASR 32 and above: result all op[31], C=op[31].
- DONE: lasts one cycle; done=1; returns to IDLE next cycle.
- Latency: done is high in cycle 1+ceil(E/STEP) after the accept edge (cycle 1 when E=0).
- busy is high from cycle 1 through the DONE cycle inclusive.
- A new start is accepted at the earliest in the cycle after DONE.
- result and carry_out:
  - Registered outputs; they hold the last completed values until the next accept.
  - During RUN they show intermediate values; consumers sample them only on done.
- Width rules:
  - The remaining counter is 6 bits (max 33) and never underflows.
  - Amounts 34–255 behave exactly as 33 (LSL/LSR) or 32 (ASR).

Test Plan:
- LSL: STEP=4, operand=0xF31F3DC7, amount=4, carry_in=0 -> result=0x31F3DC70, carry_out=1, done in cycle 2, busy high cycles 1–2.
- LSR 32: operand=0x80000001, amount=32 -> result=0x00000000, carry_out=1, done at cycle 9. LSL 33 on the same operand -> result=0, carry_out=0, done at cycle 10.
- ASR: operand=0x80000000, amount=40 -> result=0xFFFFFFFF, carry_out=1, done at cycle 9. ASR 4 of 0x7000000F -> result=0x07000000, carry_out=1.
- ROR:
  - operand=0x12345678, amount=8 -> result=0x78123456, carry_out=0, done at cycle 3.
  - amount=32, operand=0x80000000 -> result=0x80000000, carry_out=1, done at cycle 1.
  - amount=0, carry_in=1 -> result=operand, carry_out=1, done at cycle 1.
- Protocol:
  - A second start with new inputs during RUN is ignored; the first result is unchanged.
  - reset asserted during RUN -> all outputs 0 immediately, no done; a start after reset works normally.
  - Regression: back-to-back starts issued the cycle after each done are all accepted.

Source files
------------

// File: rtl/shift_operand_sequencer.sv
// shift_operand_sequencer: multi-cycle register-specified shifter for the
// data-processing operand. Steps a STEP-bit-per-cycle shifter and reproduces
// the ARM boundary results for shift amounts 0, 32 and above 32.
module shift_operand_sequencer #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  shift_type,
    input  logic [7:0]  amount,
    input  logic [31:0] operand,
    input  logic        carry_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        carry_out
);

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t      state;
    logic [1:0]  typ_q;
    logic        sign_q;
    logic [5:0]  rem_q;

    logic [5:0]  eff_cnt;
    logic        zero_c;
    logic [31:0] step_res;
    logic        step_c;
    logic [5:0]  step_n;
    logic [5:0]  rem_next;

    // Effective bit count at accept; a zero count means the result is known
    // immediately (amount 0, or ROR by a non-zero multiple of 32).
    always_comb begin
        eff_cnt = 6'd0;
        case (shift_type)
            SH_LSL, SH_LSR: eff_cnt = (amount > 8'd33) ? 6'd33 : amount[5:0];
            SH_ASR:         eff_cnt = (amount > 8'd32) ? 6'd32 : amount[5:0];
            default:        eff_cnt = {1'b0, amount[4:0]};
        endcase
        zero_c = (amount == 8'd0) ? carry_in : operand[31];
    end

    // One RUN cycle: up to STEP single-bit shifts, stopping when the
    // remaining count runs out so the counter never underflows.
    always_comb begin
        step_res = result;
        step_c   = carry_out;
        step_n   = 6'd0;
        for (int i = 0; i < STEP; i++) begin
            if (6'(i) < rem_q) begin
                case (typ_q)
                    SH_LSL: begin
                        step_c   = step_res[31];
                        step_res = {step_res[30:0], 1'b0};
                    end
                    SH_LSR: begin
                        step_c   = step_res[0];
                        step_res = {1'b0, step_res[31:1]};
                    end
                    SH_ASR: begin
                        step_c   = step_res[0];
                        step_res = {sign_q, step_res[31:1]};
                    end
                    default: begin
                        step_res = {step_res[0], step_res[31:1]};
                        step_c   = step_res[31];
                    end
                endcase
                step_n = step_n + 6'd1;
            end
        end
        rem_next = rem_q - step_n;
    end

    // Sequencer FSM with registered busy/done/result/carry_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            typ_q     <= SH_LSL;
            sign_q    <= 1'b0;
            rem_q     <= 6'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= 32'd0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        typ_q  <= shift_type;
                        sign_q <= operand[31];
                        result <= operand;
                        busy   <= 1'b1;
                        if (eff_cnt == 6'd0) begin
                            carry_out <= zero_c;
                            rem_q     <= 6'd0;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            carry_out <= carry_in;
                            rem_q     <= eff_cnt;
                            state     <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    result    <= step_res;
                    carry_out <= step_c;
                    rem_q     <= rem_next;
                    if (rem_next == 6'd0) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
